datamem_lsu: RTL and testbench

Load/store unit on the initiator side of the datamem port: it accepts CPU load/store requests and drives datamem's address/datain/WE/writebyte/writehalfword.
- Checks range and alignment, sequences the single-cycle write strobe, and registers read data with zero- or sign-extension.
- Returns a response through a valid/ready handshake.
- Sits between execute stage and datamem; pairs with datamem using identical STARTADDR/LENGTH.

---
 rtl/datamem_lsu.sv | 193 +++++++++++++++++++
 tb/tb_datamem_lsu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_lsu.sv
// datamem_lsu: load/store unit driving the datamem port from the CPU side.
//
// Accepts one load/store request at a time through a valid/ready handshake.
// Each request is checked for size, alignment and range when it is accepted.
// A legal request spends one ACCESS cycle on the memory port. A store raises
// mem_we and its size strobe for that cycle; a load samples mem_data at the
// edge that leaves ACCESS. The response is then held until the consumer
// accepts it. A rejected request skips the memory port, returns
// resp_fault=1, and bumps a saturating fault counter.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_write, req_size        1=store; size 00 byte, 01 half, 10 word, 11 illegal
//   req_signed                 loads: 1=sign-extend, 0=zero-extend
//   req_addr, req_wdata        byte address, low-aligned store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_fault     extended load data (0 for stores/faults), fault flag
//   fault_count                saturating count of faulted requests
//   mem_address, mem_datain    datamem address / write data
//   mem_we, mem_writebyte,
//   mem_writehalfword          datamem write strobes (only asserted in ACCESS)
//   mem_data                   datamem combinational read data
module datamem_lsu #(
  parameter logic [31:0] STARTADDR = 32'h1000_0000,
  parameter logic [31:0] LENGTH    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [15:0] fault_count,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  output logic        mem_writebyte,
  output logic        mem_writehalfword,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_datain_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [15:0] fault_count_q;

  logic        accept;
  logic        req_fault;
  logic [32:0] size_bytes;
  logic [32:0] end_addr;
  logic [32:0] limit_addr;
  logic [31:0] load_ext;

  assign accept = req_valid && (state_q == StIdle);

  // Range check is done in 33 bits so an access near 32'hFFFF_FFFF cannot
  // wrap around and appear to be in range.
  always_comb begin
    size_bytes = 33'd4;
    unique case (req_size)
      2'b00:   size_bytes = 33'd1;
      2'b01:   size_bytes = 33'd2;
      2'b10:   size_bytes = 33'd4;
      default: size_bytes = 33'd4;
    endcase
  end

  assign end_addr   = {1'b0, req_addr} + size_bytes;
  assign limit_addr = {1'b0, STARTADDR} + {1'b0, LENGTH};

  always_comb begin
    req_fault = 1'b0;
    if (req_size == 2'b11)                          req_fault = 1'b1;
    if ((req_size == 2'b01) && req_addr[0])         req_fault = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) req_fault = 1'b1;
    if (req_addr < STARTADDR)                       req_fault = 1'b1;
    if (end_addr > limit_addr)                      req_fault = 1'b1;
  end

  // Load extension of the combinational read data; sampled leaving ACCESS.
  always_comb begin
    load_ext = mem_data;
    unique case (size_q)
      2'b00:   load_ext = {{24{signed_q & mem_data[7]}}, mem_data[7:0]};
      2'b01:   load_ext = {{16{signed_q & mem_data[15]}}, mem_data[15:0]};
      default: load_ext = mem_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = req_fault ? StResp : StAccess;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    mem_we            = 1'b0;
    mem_writebyte     = 1'b0;
    mem_writehalfword = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StAccess: begin
        mem_we            = write_q;
        mem_writebyte     = write_q && (size_q == 2'b00);
        mem_writehalfword = write_q && (size_q == 2'b01);
      end
      StResp: resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Datapath registers. The memory port address/data are only loaded for
  // legal requests, so a faulted request leaves them at their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      mem_address_q <= STARTADDR;
      mem_datain_q  <= 32'h0;
      rdata_q       <= 32'h0;
      fault_q       <= 1'b0;
      fault_count_q <= 16'h0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        if (req_fault) begin
          rdata_q <= 32'h0;
          fault_q <= 1'b1;
          if (fault_count_q != 16'hFFFF) begin
            fault_count_q <= fault_count_q + 16'd1;
          end
        end else begin
          mem_address_q <= req_addr;
          mem_datain_q  <= req_wdata;
        end
      end
      if (state_q == StAccess) begin
        rdata_q <= write_q ? 32'h0 : load_ext;
        fault_q <= 1'b0;
      end
    end
  end

  assign mem_address = mem_address_q;
  assign mem_datain  = mem_datain_q;
  assign resp_rdata  = rdata_q;
  assign resp_fault  = fault_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_datamem_lsu.sv
module tb_datamem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [15:0] fault_count;
  logic [31:0] mem_address;
  logic [31:0] mem_datain;
  logic        mem_we;
  logic        mem_writebyte;
  logic        mem_writehalfword;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  datamem_lsu #(
    .STARTADDR(32'h1000_0000),
    .LENGTH   (32'h0000_1000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .fault_count      (fault_count),
    .mem_address      (mem_address),
    .mem_datain       (mem_datain),
    .mem_we           (mem_we),
    .mem_writebyte    (mem_writebyte),
    .mem_writehalfword(mem_writehalfword),
    .mem_data         (mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (DUT must be idle); returns after accept.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_ready_back"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic load_check(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] md,
                            input logic [31:0] exp);
    mem_data = md;
    issue(1'b0, sz, sg, a, 32'h0);
    chk({tag, "_acc_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, "_acc_addr"}, mem_address, a);
    step();
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_fault"}, {31'h0, resp_fault}, 32'h0);
    finish_resp(tag);
  endtask

  task automatic fault_check(input string tag, input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [15:0] cnt);
    issue(w, sz, 1'b0, a, 32'h5555_5555);
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_fault"}, {31'h0, resp_fault}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, "_count"}, {16'h0, fault_count}, {16'h0, cnt});
    finish_resp(tag);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; mem_data = 32'h0;
    step(); step();
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_fault_count", {16'h0, fault_count}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h1000_0000);
    chk("rst_mem_datain", mem_datain, 32'h0);
    reset = 1'b0;

    // Reset while a store sits in ACCESS.
    issue(1'b1, 2'b10, 1'b0, 32'h1000_0020, 32'h1234_5678);
    chk("rstacc_we_before", {31'h0, mem_we}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstacc_we", {31'h0, mem_we}, 32'h0);
    chk("rstacc_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstacc_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rstacc_mem_address", mem_address, 32'h1000_0000);

    // Store word.
    issue(1'b1, 2'b10, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF);
    chk("sw_we", {31'h0, mem_we}, 32'h1);
    chk("sw_wb", {31'h0, mem_writebyte}, 32'h0);
    chk("sw_wh", {31'h0, mem_writehalfword}, 32'h0);
    chk("sw_addr", mem_address, 32'h1000_0010);
    chk("sw_datain", mem_datain, 32'hDEAD_BEEF);
    chk("sw_ready", {31'h0, req_ready}, 32'h0);
    step();
    chk("sw_we_once", {31'h0, mem_we}, 32'h0);
    chk("sw_valid", {31'h0, resp_valid}, 32'h1);
    chk("sw_fault", {31'h0, resp_fault}, 32'h0);
    chk("sw_rdata", resp_rdata, 32'h0);
    finish_resp("sw");

    load_check("lw", 2'b10, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_check("lb", 2'b00, 1'b1, 32'h1000_0011, 32'h0000_8081, 32'hFFFF_FF81);
    load_check("lbu", 2'b00, 1'b0, 32'h1000_0011, 32'h0000_8081, 32'h0000_0081);
    load_check("lh", 2'b01, 1'b1, 32'h1000_0012, 32'h0000_8081, 32'hFFFF_8081);
    load_check("lhu", 2'b01, 1'b0, 32'h1000_0012, 32'h0000_8081, 32'h0000_8081);

    // Store byte.
    issue(1'b1, 2'b00, 1'b0, 32'h1000_0020, 32'h0000_00AB);
    chk("sb_we", {31'h0, mem_we}, 32'h1);
    chk("sb_wb", {31'h0, mem_writebyte}, 32'h1);
    chk("sb_wh", {31'h0, mem_writehalfword}, 32'h0);
    chk("sb_datain", mem_datain, 32'h0000_00AB);
    step();
    chk("sb_wb_drop", {31'h0, mem_writebyte}, 32'h0);
    finish_resp("sb");

    // Store half.
    issue(1'b1, 2'b01, 1'b0, 32'h1000_0022, 32'h0000_BEEF);
    chk("sh_wh", {31'h0, mem_writehalfword}, 32'h1);
    chk("sh_wb", {31'h0, mem_writebyte}, 32'h0);
    step();
    finish_resp("sh");

    fault_check("f_lw_mis", 1'b0, 2'b10, 32'h1000_0002, 16'd1);
    fault_check("f_lh_mis", 1'b0, 2'b01, 32'h1000_0001, 16'd2);
    fault_check("f_lw_over", 1'b0, 2'b10, 32'h1000_0FFD, 16'd3);
    fault_check("f_sb_low", 1'b1, 2'b00, 32'h0FFF_FFFF, 16'd4);
    chk("f_addr_held", mem_address, 32'h1000_0022);
    fault_check("f_size11", 1'b0, 2'b11, 32'h1000_0000, 16'd5);
    fault_check("f_lb_end", 1'b0, 2'b00, 32'h1000_1000, 16'd6);
    fault_check("f_lw_wrap", 1'b0, 2'b10, 32'hFFFF_FFFC, 16'd7);

    // Boundaries.
    load_check("lw_top", 2'b10, 1'b0, 32'h1000_0FFC, 32'hCAFE_F00D, 32'hCAFE_F00D);
    issue(1'b1, 2'b00, 1'b0, 32'h1000_0FFF, 32'h0000_0077);
    chk("sb_top_we", {31'h0, mem_we}, 32'h1);
    step();
    chk("sb_top_fault", {31'h0, resp_fault}, 32'h0);
    finish_resp("sb_top");

    // Backpressure with a waiting request.
    mem_data = 32'h1122_3344;
    issue(1'b0, 2'b10, 1'b0, 32'h1000_0100, 32'h0);
    step();
    mem_data   = 32'h0000_00F0;
    req_write  = 1'b0; req_size = 2'b00; req_signed = 1'b1;
    req_addr   = 32'h1000_0004; req_wdata = 32'h0;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp_rdata", resp_rdata, 32'h1122_3344);
      chk("bp_ready", {31'h0, req_ready}, 32'h0);
      chk("bp_addr", mem_address, 32'h1000_0100);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("bp_idle_valid", {31'h0, resp_valid}, 32'h0);
    chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    chk("bp_acc_addr", mem_address, 32'h1000_0004);
    chk("bp_acc_ready", {31'h0, req_ready}, 32'h0);
    step();
    chk("bp_lb_rdata", resp_rdata, 32'hFFFF_FFF0);
    chk("bp_lb_valid", {31'h0, resp_valid}, 32'h1);
    finish_resp("bp_lb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
